deflect_port_arbiter: RTL
=========================

// Module: deflect_port_arbiter
// PURPOSE
// - Output-port allocator for one 4-port MinBD deflection router stage; sits after pipeline_two.
// - Each cycle it maps up to 4 incoming flits (N,S,E,W) plus one local injection onto the 4 output ports.
//   * Every valid flit always leaves on some port; losers are deflected.
//   * At most one local-destined flit ejects per cycle.
// - Rotating-priority epochs guarantee livelock freedom.
// PARAMETERS
// - MY_X          0    router X coordinate (2 bit)
// - MY_Y          0    router Y coordinate (2 bit)
// - EPOCH_CYCLES  16   cycles per priority epoch; >=1
// PORTS
// - clk       in   1   sole clock; rising edge
// - rst       in   1   asynchronous, active-high reset
// - nty,sty,ety,wty  in  11  input flits from N,S,E,W
// - inj_flit  in  11   local injection flit
// - inj_valid in   1   injection request; hold until inj_ack
// - ej_ready  in   1   local sink can take a flit this cycle
// - nxt,sxt,ext,wxt  out 11  registered output flits to N,S,E,W
// - ej_flit   out 11   registered ejected flit
// - inj_ack   out  1   registered one-cycle pulse: inj_flit was accepted
// - prio_ptr  out  2   current highest-priority input (0=N,1=S,2=E,3=W)
// BEHAVIOUR
// - Flit format
//   * [10] valid; [9:8] dst_x; [7:6] dst_y; [5:0] payload.
//   * Invalid flit = 11'b0. Never drive z or x.
// - Reset: all outputs 11'b0; inj_ack=0; prio_ptr=0; epoch counter=0.
//   * Reset mid-traffic drops in-flight flits. This is legal.
// - Latency: exactly 1 cycle, inputs to registered outputs. No internal storage beyond the output regs.
// - Productive ports per flit:
//   * dst_x>MY_X -> E; dst_x<MY_X -> W.
//   * dst_y>MY_Y -> N; dst_y<MY_Y -> S.
//   * X preference first, Y second.
//   * dst==(MY_X,MY_Y) -> local.
// - Allocation order: inputs served in priority order prio_ptr, prio_ptr+1, ... (mod 4). Each input:
//   1) Local flit: takes eject if ej_ready and eject not yet taken this cycle. Otherwise it is deflected (step 4).
//   2) First productive port if free.
//   3) Else second productive port if free.
//   4) Else lowest-index free output (order N,S,E,W). This is the deflection.
// - Injection after all inputs:
//   * If inj_valid and a port is still free, inj_flit is allocated by the same rules 1-4. inj_ack=1 next cycle.
//   * Exception: a local-destined inj_flit never ejects; it is deflected.
//   * Otherwise inj_ack=0. Requester holds the flit.
// - Invariants:
//   * #valid inputs <= 4 == #ports, so no flit is ever dropped.
//   * Output count of valid flits == input valid count + inj_ack.
// - Epoch:
//   * The counter increments each cycle.
//   * When the counter == EPOCH_CYCLES-1, it wraps to 0 and prio_ptr increments mod 4 (3 -> 0).
// - Simultaneous events:
//   * Ties are resolved only by priority order; no randomness.
//   * An epoch wrap affects allocation from the following cycle.
// STRUCTURE
// - Shared package (router_pkg): FLIT_W=11; bit-field positions; port index constants N=0,S=1,E=2,W=3; INVALID_FLIT.
// - One natural sub-module: route_compute. Combinational; flit -> {local, pref1, pref2, has_pref2}. Instantiated 5x.
// - Top: priority sequential allocation (combinational chain), output/eject/ack registers, epoch counter.
// TESTING
// - Reset: assert rst async mid-cycle -> all outputs 11'b0, inj_ack=0, prio_ptr=0 immediately.
// - Single flit: MY=(1,1), nty={1,2'd3,2'd1,6'h2A} -> next cycle ext=that flit; nxt, sxt, wxt = 0.
// - Contention: prio_ptr=0.
//   * nty and sty both carry dst (3,1).
//   * Next cycle: ext=nty flit; sty flit deflected to nxt (lowest free).
// - Eject:
//   * Stimulus: MY=(1,1); ety and wty both carry dst (1,1); ej_ready=1; prio_ptr=0.
//   * Next cycle: ej_flit=ety flit.
//   * Next cycle: wty flit on nxt.
//   * With ej_ready=0: both are deflected, to nxt and sxt.
// - Injection:
//   * 4 valid inputs + inj_valid -> inj_ack=0, held.
//   * Next cycle 3 valid inputs -> injected flit appears on the remaining port, inj_ack=1 for exactly one cycle.
// - Epoch: EPOCH_CYCLES=4 -> prio_ptr sequence 0,0,0,0,1,1,1,1,2...; after 3 it wraps to 0.
//   * Repeat the contention test with prio_ptr=1: sty now wins E.

Source files
------------

// File: rtl/router_pkg.sv
// Shared flit layout, port indices and output-port selection helpers for the
// MinBD deflection router stage.
package router_pkg;

    localparam int FLIT_W    = 11;
    localparam int VALID_BIT = 10;
    localparam int DX_HI     = 9;
    localparam int DX_LO     = 8;
    localparam int DY_HI     = 7;
    localparam int DY_LO     = 6;

    localparam logic [1:0] PORT_N = 2'd0;
    localparam logic [1:0] PORT_S = 2'd1;
    localparam logic [1:0] PORT_E = 2'd2;
    localparam logic [1:0] PORT_W = 2'd3;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam flit_t INVALID_FLIT = '0;

    // Lowest-index free output in N,S,E,W order; the deflection target.
    function automatic logic [1:0] first_free(input logic [3:0] used);
        logic [1:0] sel;
        sel = PORT_N;
        for (int p = 3; p >= 0; p--) begin
            if (!used[p]) sel = 2'(p);
        end
        return sel;
    endfunction

    // Productive port if one is free, otherwise deflect. Local flits that
    // could not eject land here too and always deflect.
    function automatic logic [1:0] choose_port(
        input logic [3:0] used,
        input logic       is_local,
        input logic [1:0] pref1,
        input logic [1:0] pref2,
        input logic       has_pref2
    );
        logic [1:0] sel;
        if (!is_local && !used[pref1]) begin
            sel = pref1;
        end else if (!is_local && has_pref2 && !used[pref2]) begin
            sel = pref2;
        end else begin
            sel = first_free(used);
        end
        return sel;
    endfunction

endpackage

// File: rtl/route_compute.sv
// Destination-to-port lookup: X-first productive port, Y second, or local
// when the destination matches this router.
module route_compute
    import router_pkg::*;
#(
    parameter logic [1:0] MY_X = 2'd0,
    parameter logic [1:0] MY_Y = 2'd0
) (
    input  logic [1:0] dst_x,
    input  logic [1:0] dst_y,
    output logic       is_local,
    output logic [1:0] pref1,
    output logic [1:0] pref2,
    output logic       has_pref2
);

    always_comb begin
        is_local  = 1'b0;
        pref1     = PORT_N;
        pref2     = PORT_N;
        has_pref2 = 1'b0;
        if (dst_x != MY_X) begin
            pref1 = (dst_x > MY_X) ? PORT_E : PORT_W;
            if (dst_y != MY_Y) begin
                has_pref2 = 1'b1;
                pref2     = (dst_y > MY_Y) ? PORT_N : PORT_S;
            end
        end else if (dst_y != MY_Y) begin
            pref1 = (dst_y > MY_Y) ? PORT_N : PORT_S;
        end else begin
            is_local = 1'b1;
        end
    end

endmodule

// File: rtl/deflect_port_arbiter.sv
// Output-port allocator for one 4-port deflection router stage: priority-ordered
// allocation of N,S,E,W flits plus local injection, registered outputs, epochs.
module deflect_port_arbiter
    import router_pkg::*;
#(
    parameter logic [1:0] MY_X         = 2'd0,
    parameter logic [1:0] MY_Y         = 2'd0,
    parameter int         EPOCH_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] nty,
    input  logic [FLIT_W-1:0] sty,
    input  logic [FLIT_W-1:0] ety,
    input  logic [FLIT_W-1:0] wty,
    input  logic [FLIT_W-1:0] inj_flit,
    input  logic              inj_valid,
    input  logic              ej_ready,
    output logic [FLIT_W-1:0] nxt,
    output logic [FLIT_W-1:0] sxt,
    output logic [FLIT_W-1:0] ext,
    output logic [FLIT_W-1:0] wxt,
    output logic [FLIT_W-1:0] ej_flit,
    output logic              inj_ack,
    output logic [1:0]        prio_ptr
);

    localparam int CW = (EPOCH_CYCLES > 1) ? $clog2(EPOCH_CYCLES) : 1;

    // Handshakes: inj_flit is held while inj_valid is high until a one-cycle
    // inj_ack pulse; ej_ready only permits an eject in the same cycle.
    logic [4:0][FLIT_W-1:0] flit_all;
    logic [4:0]             local_all;
    logic [4:0][1:0]        pref1_all;
    logic [4:0][1:0]        pref2_all;
    logic [4:0]             has_pref2_all;

    assign flit_all = {inj_flit, wty, ety, sty, nty};

    for (genvar g = 0; g < 5; g++) begin : g_route
        route_compute #(
            .MY_X(MY_X),
            .MY_Y(MY_Y)
        ) u_route (
            .dst_x    (flit_all[g][DX_HI:DX_LO]),
            .dst_y    (flit_all[g][DY_HI:DY_LO]),
            .is_local (local_all[g]),
            .pref1    (pref1_all[g]),
            .pref2    (pref2_all[g]),
            .has_pref2(has_pref2_all[g])
        );
    end

    logic [3:0]             used;
    logic                   ej_taken;
    logic [1:0]             idx;
    logic [1:0]             port;
    logic [3:0][FLIT_W-1:0] out_d;
    logic [FLIT_W-1:0]      ej_d;
    logic                   ack_d;

    always_comb begin
        used     = '0;
        ej_taken = 1'b0;
        idx      = '0;
        port     = '0;
        out_d    = '0;
        ej_d     = INVALID_FLIT;
        ack_d    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = prio_ptr + 2'(i);
            if (flit_all[idx][VALID_BIT]) begin
                if (local_all[idx] && ej_ready && !ej_taken) begin
                    ej_d     = flit_all[idx];
                    ej_taken = 1'b1;
                end else begin
                    port        = choose_port(used, local_all[idx], pref1_all[idx],
                                              pref2_all[idx], has_pref2_all[idx]);
                    used[port]  = 1'b1;
                    out_d[port] = flit_all[idx];
                end
            end
        end
        // Injection never ejects: a local-destined inj_flit is deflected.
        if (inj_valid && (used != 4'b1111)) begin
            port        = choose_port(used, local_all[4], pref1_all[4],
                                      pref2_all[4], has_pref2_all[4]);
            used[port]  = 1'b1;
            out_d[port] = inj_flit;
            ack_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nxt     <= INVALID_FLIT;
            sxt     <= INVALID_FLIT;
            ext     <= INVALID_FLIT;
            wxt     <= INVALID_FLIT;
            ej_flit <= INVALID_FLIT;
            inj_ack <= 1'b0;
        end else begin
            nxt     <= out_d[PORT_N];
            sxt     <= out_d[PORT_S];
            ext     <= out_d[PORT_E];
            wxt     <= out_d[PORT_W];
            ej_flit <= ej_d;
            inj_ack <= ack_d;
        end
    end

    logic [CW-1:0] epoch_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            epoch_cnt <= '0;
            prio_ptr  <= 2'd0;
        end else if (epoch_cnt == CW'(EPOCH_CYCLES - 1)) begin
            epoch_cnt <= '0;
            prio_ptr  <= prio_ptr + 2'd1;
        end else begin
            epoch_cnt <= epoch_cnt + 1'b1;
        end
    end

endmodule
